// File: rtl/uart_pkg.sv
// Shared UART subsystem constants and the receive-controller state type.
package uart_pkg;
    localparam int BYTE_W     = 8;
    localparam int FIFO_DEPTH = 16;
    localparam int BIT_RATE   = 9600;
    localparam int CLK_HZ     = 100_000_000;

    typedef enum logic [1:0] {IDLE, ARM, BUSY} rx_state_e;
endpackage

// File: rtl/uart_rx_fifo_if.sv
// Receiver-side handshake and consumer stream of the receive byte buffer.
interface uart_rx_fifo_if #(
    parameter int DEPTH  = uart_pkg::FIFO_DEPTH,
    parameter int BYTE_W = uart_pkg::BYTE_W
);
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic              rx_valid_o;
    logic              rx_ready_i;
    logic [BYTE_W-1:0] rx_data_i;
    logic [BYTE_W-1:0] m_data_o;
    logic              m_valid_o;
    logic              m_ready_i;
    logic [LVL_W-1:0]  level_o;
    logic              overflow_o;

    modport slave (
        output rx_valid_o, m_data_o, m_valid_o, level_o, overflow_o,
        input  rx_ready_i, rx_data_i, m_ready_i
    );

    modport master (
        input  rx_valid_o, m_data_o, m_valid_o, level_o, overflow_o,
        output rx_ready_i, rx_data_i, m_ready_i
    );
endinterface

// File: rtl/uart_sync_fifo.sv
// Synchronous first-word-fall-through FIFO; pointers carry an extra MSB to tell full from empty.
module uart_sync_fifo #(
    parameter  int DEPTH  = 16,
    parameter  int BYTE_W = 8,
    localparam int PTR_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              push_i,
    input  logic              pop_i,
    input  logic [BYTE_W-1:0] wdata_i,
    output logic [BYTE_W-1:0] rdata_o,
    output logic              full_o,
    output logic              empty_o,
    output logic [PTR_W-1:0]  level_o
);
    logic [BYTE_W-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_q, wr_d;
    logic [PTR_W-1:0]  rd_q, rd_d;
    logic              do_push;
    logic              do_pop;

    assign empty_o = (wr_q == rd_q);
    assign full_o  = (wr_q[PTR_W-1] != rd_q[PTR_W-1]) &&
                     (wr_q[PTR_W-2:0] == rd_q[PTR_W-2:0]);

    // A pop frees the slot in the same cycle, so push-at-full is accepted alongside it.
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    assign wr_d    = wr_q + PTR_W'(do_push);
    assign rd_d    = rd_q + PTR_W'(do_pop);
    assign level_o = wr_q - rd_q;
    assign rdata_o = mem_q[rd_q[PTR_W-2:0]];

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            wr_q <= '0;
            rd_q <= '0;
        end else begin
            wr_q <= wr_d;
            rd_q <= rd_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_q[PTR_W-2:0]] <= wdata_i;
        end
    end
endmodule

// File: rtl/uart_rx_fifo.sv
// Arms the UART receiver, captures completed bytes into a FIFO and streams them out.
// Optional UART_RX_FIFO_DROP_EN: keep arming while full, drop bytes and flag overflow_o.
module uart_rx_fifo #(
    parameter int DEPTH  = uart_pkg::FIFO_DEPTH,
    parameter int BYTE_W = uart_pkg::BYTE_W
) (
    input  logic           clk_i,
    input  logic           reset_i,
    uart_rx_fifo_if.slave  bus
);
    import uart_pkg::*;

    localparam int LVL_W = $clog2(DEPTH) + 1;

    rx_state_e        state_q, state_d;
    logic             rx_valid;
    logic             slot_avail;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    logic [LVL_W-1:0] level;

    always_comb begin
        state_d  = state_q;
        rx_valid = 1'b0;
        unique case (state_q)
            IDLE: if (bus.rx_ready_i && slot_avail) state_d = ARM;
            ARM: begin
                rx_valid = 1'b1;
                if (!bus.rx_ready_i) state_d = BUSY;
            end
            BUSY:    if (bus.rx_ready_i) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) state_q <= IDLE;
        else         state_q <= state_d;
    end

    // Receiver back at idle while we wait in BUSY marks a finished frame.
    assign push = (state_q == BUSY) && bus.rx_ready_i;
    assign pop  = ~empty & bus.m_ready_i;

    uart_sync_fifo #(.DEPTH(DEPTH), .BYTE_W(BYTE_W)) u_fifo (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .push_i  (push),
        .pop_i   (pop),
        .wdata_i (bus.rx_data_i),
        .rdata_o (bus.m_data_o),
        .full_o  (full),
        .empty_o (empty),
        .level_o (level)
    );

    assign bus.rx_valid_o = rx_valid;
    assign bus.m_valid_o  = ~empty;
    assign bus.level_o    = level;

`ifdef UART_RX_FIFO_DROP_EN
    logic overflow_q, overflow_d;

    assign slot_avail = 1'b1;
    assign overflow_d = overflow_q | (push & full & ~pop);

    always_ff @(posedge clk_i) begin
        if (reset_i) overflow_q <= 1'b0;
        else         overflow_q <= overflow_d;
    end

    assign bus.overflow_o = overflow_q;
`else
    assign slot_avail     = ~full;
    assign bus.overflow_o = 1'b0;
`endif
endmodule

// File: doc/uart_rx_fifo.md
# uart_rx_fifo

Receive-side byte buffer sitting directly downstream of the UART receiver. It arms the receiver through the receiver's valid/ready handshake and detects frame completion. It captures each received byte into a synchronous FIFO and presents bytes to the system on a first-word-fall-through valid/ready stream, so the consumer no longer has to poll the receiver per byte.

## Interface
- DEPTH, 16: FIFO entries; power of two, minimum 2.
- BYTE_W, 8: byte width; must match receiver data width.
- clk_i  in  1  system clock (100 MHz in the UART subsystem).
- reset_i  in  1  synchronous, active-high reset.
- rx_valid_o  out  1  arm request to receiver valid_i.
- rx_ready_i  in  1  receiver ready_o; high = receiver idle.
- rx_data_i  in  BYTE_W  receiver data_o; stable while receiver idle.
- m_data_o  out  BYTE_W  head-of-FIFO byte.
- m_valid_o  out  1  FIFO non-empty.
- m_ready_i  in  1  consumer accepts m_data_o when m_valid_o is also high.
- level_o  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- overflow_o  out  1  sticky: byte discarded because the FIFO was full.

## Operation
- Controller FSM has three states: IDLE, ARM, BUSY. Reset state is IDLE.
- IDLE -> ARM when rx_ready_i=1 and a slot is available. A slot is available when level_o<DEPTH, or at any time when UART_RX_FIFO_DROP_EN is defined. Otherwise IDLE holds.
- ARM: rx_valid_o=1. ARM -> BUSY when rx_ready_i=0 (receiver has left idle). Otherwise ARM holds, with rx_valid_o kept high.
- BUSY: rx_valid_o=0. On rx_ready_i=1, the byte is complete: push rx_data_i and go to IDLE.
- rx_valid_o is a Moore output: 1 only in ARM.
- FIFO: circular buffer. Read and write pointers are $clog2(DEPTH)+1 bits, and the MSB distinguishes full from empty. Pointers wrap from DEPTH-1 to 0.
- Push: write mem[wr], then wr+1. Pop (m_valid_o & m_ready_i): rd+1. m_data_o = mem[rd], read combinationally.
- Simultaneous push and pop: level unchanged, both pointers advance. This is legal at full and at empty+1.
- Pop while empty is ignored. The consumer cannot cause it, because m_valid_o=0.
- Push while full can only occur with DROP_EN. Its required response is in Configuration.
- Reset values: rx_valid_o=0, m_valid_o=0, level_o=0, overflow_o=0, m_data_o don't-care. Pointers are 0 and the FSM is in IDLE.
- Reset mid-byte: FIFO contents are discarded. The FSM re-arms only after it sees rx_ready_i=1, so a partially received frame is never pushed.

## Timing
- Frame completion is seen in cycle T (BUSY, rx_ready_i=1). The byte is written at the end of T, so m_valid_o/m_data_o are valid in T+1 and level_o increments in T+1.
- Re-arm: IDLE at T+1, ARM at T+2. The receiver is re-armed well inside the stop-bit period at 9600 baud, so back-to-back frames are not lost.
- A pop in cycle P updates level_o/m_data_o in P+1.
- Throughput: one push and one pop per cycle.

## Configuration
- UART_RX_FIFO_DROP_EN defined:
  - The receiver is armed even when the FIFO is full.
  - A completed byte that arrives with level_o=DEPTH and no same-cycle pop is discarded and sets overflow_o=1. Pointers and level are unchanged.
  - If a pop coincides with that byte, the byte is stored.
  - overflow_o clears only on reset_i.
- UART_RX_FIFO_DROP_EN undefined:
  - The receiver is not armed while full, so line data arriving meanwhile is never sampled.
  - overflow_o is tied to 0.

## Structure
- Shared package uart_pkg:
  - FSM state typedef (IDLE/ARM/BUSY);
  - BYTE_W;
  - default FIFO DEPTH;
  - BIT_RATE and CLK_HZ constants, shared with the receiver.
- One sub-module, uart_sync_fifo: generic DEPTH x BYTE_W FIFO with push/pop/full/empty/level outputs. The top level holds the FSM and overflow logic.

## Test plan
- Single byte 0xA5 at 9600 baud, m_ready_i=1 → rx_valid_o pulses, m_valid_o high one cycle after the receiver returns idle, m_data_o=0xA5, level_o 1→0.
- 16 back-to-back bytes 0x00..0x0F with m_ready_i=0 → level_o=16. Popping then yields 0x00..0x0F in order, with a pointer wrap on the next fill.
- Without DROP_EN: FIFO full, 17th frame on line → rx_valid_o stays 0, level_o=16, overflow_o=0. After one pop, re-arm occurs and the next frame is stored.
- With DROP_EN: full FIFO plus 17th frame 0x3C → overflow_o=1, contents unchanged. The same frame completing with a same-cycle pop → 0x3C stored, level_o stays 16.
- reset_i asserted mid-frame with 3 bytes buffered → level_o=0, m_valid_o=0 next cycle. No partial byte is pushed, and the next full frame 0x5A is received correctly.
- Simultaneous push and pop at level_o=1 → level_o stays 1, m_data_o shows the new byte.
